// File: rtl/alu_pkg.sv
// Shared ALU definitions: the 4-bit ALU_Operation codes (also imported by the
// ALU control decoder), the execution-unit FSM state encoding, and a helper
// that classifies the iterative shift operations.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_SLTU = 4'b1110;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } alu_state_e;

    // True for the opcodes that run through the one-bit-per-cycle shifter.
    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One-bit combinational shift of a WIDTH-bit value. Left shifts fill with 0;
// right shifts fill with 0 or, when arith is set, with the sign bit.
module alu_shift_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] din,
    input  logic             dir_left,
    input  logic             arith,
    output logic [WIDTH-1:0] dout
);

    // Select the shift direction and the fill bit for a right shift.
    always_comb begin
        dout = din;
        if (dir_left) begin
            dout = {din[WIDTH-2:0], 1'b0};
        end else begin
            dout = {arith & din[WIDTH-1], din[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: accepts an operation on a valid/ready handshake, runs
// logic/arithmetic in one cycle and shifts at one bit per cycle, then holds
// Result/Zero/Error until the downstream stage takes them.
// Optional feature: define ALU_EXEC_OVERFLOW_EN to add the signed Overflow
// output for add/sub.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         ALU_Operation,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [SHAMT_W-1:0] Shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   Result,
    output logic               Zero,
    output logic               Error
`ifdef ALU_EXEC_OVERFLOW_EN
    ,
    output logic               Overflow
`endif
);

    alu_state_e         state_r;
    alu_state_e         state_nxt_s;
    logic [3:0]         op_r;
    logic [SHAMT_W-1:0] cnt_r;
    logic [WIDTH-1:0]   result_r;
    logic               zero_r;
    logic               error_r;
    logic               accept_s;
    logic [WIDTH-1:0]   alu_res_s;
    logic               alu_err_s;
    logic [WIDTH-1:0]   shift_s;

    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign accept_s  = in_valid && (state_r == IDLE);
    assign Result    = result_r;
    assign Zero      = zero_r;
    assign Error     = error_r;

    // Single-cycle operations; shift opcodes load B as the shifter's start value.
    always_comb begin
        alu_res_s = {WIDTH{1'b0}};
        alu_err_s = 1'b0;
        case (ALU_Operation)
            ALU_ADD:  alu_res_s = A + B;
            ALU_SUB:  alu_res_s = A - B;
            ALU_AND:  alu_res_s = A & B;
            ALU_OR:   alu_res_s = A | B;
            ALU_XOR:  alu_res_s = A ^ B;
            ALU_NOR:  alu_res_s = ~(A | B);
            ALU_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            ALU_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (A < B)};
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  alu_res_s = B;
            default: begin
                alu_res_s = {WIDTH{1'b0}};
                alu_err_s = 1'b1;
            end
        endcase
    end

    alu_shift_step #(
        .WIDTH (WIDTH)
    ) u_shift_step (
        .din      (result_r),
        .dir_left (op_r == ALU_SLL),
        .arith    (op_r == ALU_SRA),
        .dout     (shift_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: a zero shift amount skips SHIFT; DONE waits for out_ready.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (is_shift_op(ALU_Operation) && (Shamt != {SHAMT_W{1'b0}})) begin
                        state_nxt_s = SHIFT;
                    end else begin
                        state_nxt_s = DONE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r == SHAMT_W'(1)) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Datapath registers: load on accept, shift one bit per SHIFT cycle, hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r     <= 4'b0000;
            cnt_r    <= {SHAMT_W{1'b0}};
            result_r <= {WIDTH{1'b0}};
            zero_r   <= 1'b1;
            error_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        op_r     <= ALU_Operation;
                        cnt_r    <= Shamt;
                        result_r <= alu_res_s;
                        zero_r   <= (alu_res_s == {WIDTH{1'b0}});
                        error_r  <= alu_err_s;
                    end
                end
                SHIFT: begin
                    cnt_r    <= cnt_r - SHAMT_W'(1);
                    result_r <= shift_s;
                    zero_r   <= (shift_s == {WIDTH{1'b0}});
                end
                default: begin
                    result_r <= result_r;
                end
            endcase
        end
    end

`ifdef ALU_EXEC_OVERFLOW_EN
    logic ovf_r;
    logic alu_ovf_s;

    assign Overflow = ovf_r;

    // Signed overflow of add/sub, judged from the operand and result sign bits.
    always_comb begin
        alu_ovf_s = 1'b0;
        if (ALU_Operation == ALU_ADD) begin
            alu_ovf_s = (A[WIDTH-1] == B[WIDTH-1]) && (alu_res_s[WIDTH-1] != A[WIDTH-1]);
        end else if (ALU_Operation == ALU_SUB) begin
            alu_ovf_s = (A[WIDTH-1] != B[WIDTH-1]) && (alu_res_s[WIDTH-1] != A[WIDTH-1]);
        end else begin
            alu_ovf_s = 1'b0;
        end
    end

    // Overflow flag is captured with the operation and held until the next accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_r <= 1'b0;
        end else if (accept_s) begin
            ovf_r <= alu_ovf_s;
        end else begin
            ovf_r <= ovf_r;
        end
    end
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: the driver pushes model results into a
// queue at accept time, a monitor pops and compares on each output handshake.
module tb_alu_exec_unit;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        err;
        logic        ovf;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ALU_Operation;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  Shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Result;
    logic        Zero;
    logic        Error;
`ifdef ALU_EXEC_OVERFLOW_EN
    logic        Overflow;
`endif

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   hold_lo = 0;
    bit   seen = 1'b0;

    alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .ALU_Operation (ALU_Operation),
        .A             (A),
        .B             (B),
        .Shamt         (Shamt),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .Result        (Result),
        .Zero          (Zero),
        .Error         (Error)
`ifdef ALU_EXEC_OVERFLOW_EN
        ,
        .Overflow      (Overflow)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model straight from the opcode table.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] sh);
        exp_t e;
        e.res = 32'd0; e.err = 1'b0; e.ovf = 1'b0; e.lat = 0; e.acc = 0;
        case (op)
            4'b0010: begin
                e.res = a + b;
                e.ovf = (a[31] == b[31]) && (e.res[31] != a[31]);
            end
            4'b0110: begin
                e.res = a - b;
                e.ovf = (a[31] != b[31]) && (e.res[31] != a[31]);
            end
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b0011: e.res = a ^ b;
            4'b1100: e.res = ~(a | b);
            4'b0111: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1110: e.res = (a < b) ? 32'd1 : 32'd0;
            4'b1000: begin e.res = b << sh; e.lat = int'(sh); end
            4'b1001: begin e.res = b >> sh; e.lat = int'(sh); end
            4'b1010: begin e.res = $unsigned($signed(b) >>> sh); e.lat = int'(sh); end
            default: e.err = 1'b1;
        endcase
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    // Wait (bounded) for in_ready, then present one operation for a single accept edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input bit push);
        exp_t e;
        int   t = 0;
        while (!in_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_cmp++; n_err++;
            $display("FAIL in_ready_timeout: actual=0 expected=1 (cycle %0d)", cyc);
        end
        in_valid = 1'b1; ALU_Operation = op; A = a; B = b; Shamt = sh;
        e = model(op, a, b, sh);
        @(posedge clk);
        #1;
        e.acc = cyc;
        if (push) sb.push_back(e);
        in_valid = 1'b0;
        A = $urandom; B = $urandom; ALU_Operation = 4'($urandom); Shamt = 5'($urandom);
        @(negedge clk);
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: actual=%0d pending expected=0", sb.size());
            sb.delete();
        end
    endtask

    // Downstream ready: random, or forced low for hold_lo cycles of valid output.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hold_lo > 0) begin
                out_ready = 1'b0;
                if (out_valid) hold_lo--;
            end else begin
                out_ready = ($urandom_range(0, 99) < 60);
            end
        end
    end

    // Monitor: compare every cycle of a presented result, pop on handshake.
    initial begin
        exp_t cur;
        forever begin
            @(negedge clk);
            if (out_valid && !reset) begin
                check("in_ready_while_busy", {31'd0, in_ready}, 32'd0);
                if (sb.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    cur = sb[0];
                    if (!seen) begin
                        seen = 1'b1;
                        check("latency", 32'(cyc - cur.acc), 32'(cur.lat));
                    end
                    check("result", Result, cur.res);
                    check("zero", {31'd0, Zero}, {31'd0, cur.zero});
                    check("error", {31'd0, Error}, {31'd0, cur.err});
`ifdef ALU_EXEC_OVERFLOW_EN
                    check("overflow", {31'd0, Overflow}, {31'd0, cur.ovf});
`endif
                    if (out_ready) begin
                        void'(sb.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    // Stimulus: reset, directed cases, reset-during-shift, then random traffic.
    initial begin
        reset = 1'b1; in_valid = 1'b0; ALU_Operation = 4'b0000;
        A = 32'd0; B = 32'd0; Shamt = 5'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", Result, 32'd0);
        check("rst_zero", {31'd0, Zero}, 32'd1);
        check("rst_error", {31'd0, Error}, 32'd0);

        issue(4'b0010, 32'h7FFF_FFFF, 32'd1, 5'd0, 1'b1);
        drain();
        hold_lo = 3;
        issue(4'b0110, 32'd5, 32'd5, 5'd0, 1'b1);
        drain();
        issue(4'b1010, 32'h8000_0000, 32'd0, 5'd4, 1'b1);
        issue(4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b1);
        issue(4'b1110, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b1);
        issue(4'b1000, 32'd0, 32'h0000_ABCD, 5'd16, 1'b1);
        issue(4'b1000, 32'd0, 32'h0000_ABCD, 5'd0, 1'b1);
        issue(4'b1111, 32'd3, 32'd4, 5'd0, 1'b1);
        issue(4'b0010, 32'd1, 32'd2, 5'd0, 1'b1);
        issue(4'b1001, 32'd0, 32'hF000_000F, 5'd31, 1'b1);
        drain();

        // Reset in the fifth cycle of a 20-cycle shift: nothing may come out.
        issue(4'b1000, 32'd0, 32'h1234_5678, 5'd20, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_result", Result, 32'd0);
        check("midrst_zero", {31'd0, Zero}, 32'd1);
        repeat (30) @(negedge clk);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = $urandom;
            if (i % 5 == 0) rb = ra;
            if (i % 7 == 0) ra = 32'h7FFF_FFFF;
            issue(4'($urandom), ra, rb, 5'($urandom), 1'b1);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
